// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, PC increment and fetch FSM state type
package cpu_pkg;
    localparam int PC_WIDTH    = 64;
    localparam int INSTR_WIDTH = 32;
    localparam logic [PC_WIDTH-1:0] PC_INCR = 64'd4;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational branch target: br_pc plus word offset scaled to bytes
module branch_target
    import cpu_pkg::*;
(
    input  logic [PC_WIDTH-1:0] i_br_pc,
    input  logic [PC_WIDTH-1:0] i_br_offset,
    output logic [PC_WIDTH-1:0] o_target
);
    // The shift drops the top two offset bits; the sum wraps modulo 2^64.
    assign o_target = i_br_pc + (i_br_offset << 2);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC register, IF/ID register and fetch counter
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   br_taken,
    input  logic [PC_WIDTH-1:0]    br_pc,
    input  logic [PC_WIDTH-1:0]    br_offset,
    output logic [PC_WIDTH-1:0]    if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic                   if_valid,
    output logic [31:0]            fetch_count
);
    fetch_state_t           r_state;
    fetch_state_t           w_next_state;
    logic [PC_WIDTH-1:0]    r_pc;
    logic [PC_WIDTH-1:0]    r_if_pc;
    logic [INSTR_WIDTH-1:0] r_if_instr;
    logic                   r_if_valid;
    logic [31:0]            r_fetch_count;
    logic [PC_WIDTH-1:0]    w_target;

    branch_target u_branch_target (
        .i_br_pc     (br_pc),
        .i_br_offset (br_offset),
        .o_target    (w_target)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            BOOT:    w_next_state = RUN;
            RUN:     w_next_state = RUN;
            default: w_next_state = BOOT;
        endcase
    end

    // BOOT spends one cycle presenting PC 0 so the first word is ready on the next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= '0;
            r_if_pc       <= '0;
            r_if_instr    <= '0;
            r_if_valid    <= 1'b0;
            r_fetch_count <= '0;
        end else if (r_state == RUN) begin
            if (br_taken) begin
                r_pc       <= w_target;
                r_if_pc    <= '0;
                r_if_instr <= '0;
                r_if_valid <= 1'b0;
            end else if (!stall) begin
                r_pc       <= r_pc + PC_INCR;
                r_if_pc    <= r_pc;
                r_if_instr <= imem_rdata;
                r_if_valid <= 1'b1;
                if (r_fetch_count != 32'hFFFF_FFFF) begin
                    r_fetch_count <= r_fetch_count + 32'd1;
                end
            end
        end
    end

    assign imem_addr   = r_pc;
    assign if_pc       = r_if_pc;
    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;
    assign fetch_count = r_fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_pc = '0;
    logic [63:0] br_offset = '0;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    // Reference state: what the fetch stage should hold, from the behavioural rules.
    logic        m_boot  = 1'b1;
    logic [63:0] m_pc    = '0;
    logic [63:0] m_ifpc  = '0;
    logic [31:0] m_instr = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_count = '0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_pc       (br_pc),
        .br_offset   (br_offset),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .if_valid    (if_valid),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'h9100_0421;
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    wire [192:0] dut_vec = {imem_addr, if_pc, if_instr, if_valid, fetch_count};

    function automatic logic [192:0] model_vec();
        return {m_pc, m_ifpc, m_instr, m_valid, m_count};
    endfunction

    function automatic void model_clear();
        m_boot  = 1'b1;
        m_pc    = '0;
        m_ifpc  = '0;
        m_instr = '0;
        m_valid = 1'b0;
        m_count = '0;
    endfunction

    task automatic step();
        if (reset) begin
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (br_taken) begin
                m_pc    = br_pc + br_offset * 64'd4;
                m_ifpc  = '0;
                m_instr = '0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_ifpc  = m_pc;
                m_instr = mem_word(m_pc);
                m_valid = 1'b1;
                m_pc    = m_pc + 64'd4;
                if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        stall = 1'b0;
        br_taken = 1'b0;
        reset = 1'b0;
        model_clear();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        repeat (3) step();
        checks++;
        if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL reset_state act=%h exp=%h", dut_vec, model_vec());
        end
        reset = 1'b1;
        step();
        checks++;
        if (if_valid !== 1'b0 || imem_addr !== 64'd0) begin
            errors++;
            $display("FAIL boot_edge1 act valid=%b addr=%h exp valid=0 addr=0", if_valid, imem_addr);
        end
        step();
        checks++;
        if (if_pc !== 64'd0 || if_instr !== 32'h9100_0421 || if_valid !== 1'b1 || imem_addr !== 64'd4) begin
            errors++;
            $display("FAIL first_fetch act pc=%h instr=%h valid=%b addr=%h exp pc=0 instr=91000421 valid=1 addr=4",
                     if_pc, if_instr, if_valid, imem_addr);
        end
    endtask

    task automatic test_free_run();
        restart();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (if_pc !== 64'(4 * i) || if_instr !== mem_word(64'(4 * i)) || if_valid !== 1'b1) begin
                errors++;
                $display("FAIL free_run_%0d act pc=%h instr=%h valid=%b exp pc=%h instr=%h valid=1",
                         i, if_pc, if_instr, if_valid, 64'(4 * i), mem_word(64'(4 * i)));
            end
        end
        checks++;
        if (fetch_count !== 32'd4 || imem_addr !== 64'h10) begin
            errors++;
            $display("FAIL free_run_end act count=%0d addr=%h exp count=4 addr=10", fetch_count, imem_addr);
        end
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        br_pc = 64'h10;
        br_offset = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        checks++;
        if (imem_addr !== 64'h8 || if_valid !== 1'b0 || fetch_count !== 32'd4 || if_pc !== 64'd0 || if_instr !== 32'd0) begin
            errors++;
            $display("FAIL branch_flush act addr=%h valid=%b count=%0d pc=%h instr=%h exp addr=8 valid=0 count=4 pc=0 instr=0",
                     imem_addr, if_valid, fetch_count, if_pc, if_instr);
        end
        br_taken = 1'b0;
        step();
        checks++;
        if (if_pc !== 64'h8 || if_valid !== 1'b1 || if_instr !== mem_word(64'h8) || fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL branch_refetch act pc=%h valid=%b instr=%h count=%0d exp pc=8 valid=1 instr=%h count=5",
                     if_pc, if_valid, if_instr, fetch_count, mem_word(64'h8));
        end
    endtask

    task automatic test_stall_branch();
        stall = 1'b1;
        br_taken = 1'b1;
        br_pc = 64'h20;
        br_offset = 64'd3;
        step();
        checks++;
        if (imem_addr !== 64'h2C || if_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_and_branch act addr=%h valid=%b exp addr=2c valid=0", imem_addr, if_valid);
        end
        br_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (dut_vec !== model_vec() || imem_addr !== 64'h2C || fetch_count !== 32'd5) begin
                errors++;
                $display("FAIL stall_hold_%0d act=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        stall = 1'b0;
    endtask

    task automatic test_wrap();
        br_taken = 1'b1;
        br_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        br_offset = 64'd0;
        step();
        checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_target act=%h exp=fffffffffffffffc", imem_addr);
        end
        br_taken = 1'b0;
        step();
        checks++;
        if (if_pc !== 64'hFFFF_FFFF_FFFF_FFFC || imem_addr !== 64'd0 || if_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_advance act pc=%h addr=%h valid=%b exp pc=fffffffffffffffc addr=0 valid=1",
                     if_pc, imem_addr, if_valid);
        end
    endtask

    task automatic test_async_reset();
        restart();
        step();
        repeat (7) step();
        checks++;
        if (if_valid !== 1'b1 || fetch_count !== 32'd7) begin
            errors++;
            $display("FAIL pre_reset act valid=%b count=%0d exp valid=1 count=7", if_valid, fetch_count);
        end
        br_taken = 1'b1;
        stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (if_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 64'd0 || if_pc !== 64'd0 || if_instr !== 32'd0) begin
            errors++;
            $display("FAIL async_reset act valid=%b count=%0d addr=%h pc=%h instr=%h exp all zero",
                     if_valid, fetch_count, imem_addr, if_pc, if_instr);
        end
        model_clear();
        step();
        br_taken = 1'b0;
        stall = 1'b0;
        reset = 1'b1;
        step();
        step();
        checks++;
        if (dut_vec !== model_vec() || if_instr !== 32'h9100_0421) begin
            errors++;
            $display("FAIL post_reset act=%h exp=%h", dut_vec, model_vec());
        end
    endtask

    task automatic test_random();
        restart();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 9) < 3);
            br_taken = ($urandom_range(0, 9) < 2);
            br_pc = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) br_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            br_offset = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 0) br_offset = 64'($signed($urandom_range(0, 15)) - 8);
            if ($urandom_range(0, 99) < 2) begin
                #2;
                reset = 1'b0;
                #1;
                model_clear();
                checks++;
                if (dut_vec !== model_vec()) begin
                    errors++;
                    $display("FAIL rand_async_reset_%0d act=%h exp=%h", i, dut_vec, model_vec());
                end
                reset = 1'b1;
            end
            step();
            checks++;
            if (dut_vec !== model_vec()) begin
                errors++;
                $display("FAIL rand_%0d act=%h exp=%h", i, dut_vec, model_vec());
            end
        end
        stall = 1'b0;
        br_taken = 1'b0;
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_branch();
        test_stall_branch();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately.
REQ-003 SHALL have port: imem_addr  output  64  current PC presented to instruction memory, combinationally equal to the PC register.
REQ-004 SHALL have port: imem_rdata  input  32  instruction word at imem_addr, valid same cycle.
REQ-005 SHALL have port: stall  input  1  hold PC and IF/ID register this cycle.
REQ-006 SHALL have port: br_taken  input  1  redirect fetch this cycle.
REQ-007 SHALL have port: br_pc  input  64  PC of the branching instruction.
REQ-008 SHALL have port: br_offset  input  64  sign-extended word offset from the immediate sign-extension stage.
REQ-009 SHALL have port: if_pc  output  64  registered PC of the fetched instruction.
REQ-010 SHALL have port: if_instr  output  32  registered fetched instruction.
REQ-011 SHALL have port: if_valid  output  1  if_pc/if_instr hold a live instruction.
REQ-012 SHALL have port: fetch_count  output  32  number of instructions captured since reset.

Function
REQ-013 SHALL implement FSM states BOOT and RUN; BOOT lasts exactly one cycle after reset deassertion, then RUN unconditionally.
REQ-014 In BOOT: PC held at 0, IF/ID not written, if_valid=0, stall and br_taken ignored.
REQ-015 Branch target SHALL be br_pc + (br_offset << 2), modulo 2^64; the top two offset bits are discarded.
REQ-016 In RUN, priority SHALL be br_taken > stall > normal advance.
REQ-017 br_taken=1: PC <= target; if_valid <= 0; if_instr <= 0; if_pc <= 0; fetch_count unchanged (flush, one-cycle bubble).
REQ-018 stall=1, br_taken=0: PC, if_pc, if_instr, if_valid, fetch_count all held.
REQ-019 Normal advance: if_pc <= PC; if_instr <= imem_rdata; if_valid <= 1; PC <= PC + 4 modulo 2^64; fetch_count increments.
REQ-020 Fetch latency SHALL be one cycle: the word at PC appears on if_instr on the edge after PC is presented.
REQ-021 PC wrap: PC 0xFFFF_FFFF_FFFF_FFFC advances to 0 with no error indication.
REQ-022 fetch_count SHALL saturate at 0xFFFF_FFFF.
REQ-023 Branch target with misaligned low bits is impossible by construction; br_pc[1:0] SHALL be passed through unchanged (no masking).

Reset
REQ-024 On reset=0, asynchronously: PC=0, state=BOOT, if_pc=0, if_instr=0, if_valid=0, fetch_count=0.
REQ-025 Reset asserted mid-operation SHALL clear outputs without waiting for a clock edge; a branch or stall in that cycle is discarded.
REQ-026 After reset deassertion, first live instruction (address 0) SHALL appear on the second rising edge.

Structure
REQ-027 Shared package cpu_pkg SHALL hold PC_WIDTH=64, INSTR_WIDTH=32, PC_INCR=4, and the fetch_state_t enum {BOOT, RUN}.
REQ-028 One sub-module, branch_target, SHALL compute br_pc + (br_offset << 2) combinationally; all registers stay in fetch_unit.

Verification
REQ-029 Reset low 3 cycles then release, imem[0]=0x91000421 -> edge 1: if_valid=0, imem_addr=0; edge 2: if_pc=0, if_instr=0x91000421, if_valid=1, imem_addr=4.
REQ-030 Four free-running cycles, imem[0..12] distinct -> if_pc 0,4,8,0xC in order; fetch_count=4; imem_addr=0x10.
REQ-031 In RUN, br_taken=1, br_pc=0x10, br_offset=0xFFFF_FFFF_FFFF_FFFE -> next edge PC=0x08, if_valid=0, fetch_count unchanged; following edge if_pc=0x08, if_valid=1.
REQ-032 stall=1 and br_taken=1 same cycle (br_pc=0x20, br_offset=3) -> PC=0x2C, if_valid=0; stall alone for 2 cycles -> all outputs frozen.
REQ-033 br_taken=1, br_pc=0xFFFF_FFFF_FFFF_FFFC, br_offset=0 -> PC=...FFFC; next advance -> if_pc=...FFFC, imem_addr=0.
REQ-034 Assert reset between edges with if_valid=1, fetch_count=7 -> if_valid=0, fetch_count=0, imem_addr=0 before the next edge.
